// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan decoder: active-high abcdefg
// patterns (a is the leftmost bit) and the qualifier FSM state encoding.
package seg7_pkg;

  localparam logic [1:7] SEG_0     = 7'b1111110;
  localparam logic [1:7] SEG_1     = 7'b0110000;
  localparam logic [1:7] SEG_2     = 7'b1101101;
  localparam logic [1:7] SEG_3     = 7'b1111001;
  localparam logic [1:7] SEG_4     = 7'b0110011;
  localparam logic [1:7] SEG_5     = 7'b1011011;
  localparam logic [1:7] SEG_6     = 7'b1011111;
  localparam logic [1:7] SEG_7     = 7'b1110000;
  localparam logic [1:7] SEG_8     = 7'b1111111;
  localparam logic [1:7] SEG_9     = 7'b1111011;
  localparam logic [1:7] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    IDLE,
    QUALIFY,
    HOLD
  } state_t;

endpackage

// File: rtl/seg7_pattern_lookup.sv
// Combinational segment-pattern classifier: numeral (with BCD value), blank,
// or neither. bcd is 0 whenever the pattern is not a numeral.
module seg7_pattern_lookup
  import seg7_pkg::*;
(
  input  logic [1:7] segs,
  output logic       is_numeral,
  output logic       is_blank,
  output logic [3:0] bcd
);

  always_comb begin
    is_numeral = 1'b1;
    is_blank   = 1'b0;
    bcd        = '0;
    case (segs)
      SEG_0:     bcd = 4'd0;
      SEG_1:     bcd = 4'd1;
      SEG_2:     bcd = 4'd2;
      SEG_3:     bcd = 4'd3;
      SEG_4:     bcd = 4'd4;
      SEG_5:     bcd = 4'd5;
      SEG_6:     bcd = 4'd6;
      SEG_7:     bcd = 4'd7;
      SEG_8:     bcd = 4'd8;
      SEG_9:     bcd = 4'd9;
      SEG_BLANK: begin
        is_numeral = 1'b0;
        is_blank   = 1'b1;
      end
      default:   is_numeral = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers per-digit BCD values from a multiplexed seven-segment bus; a
// {segs, dig_sel} sample must repeat STABLE_CYCLES times before it commits.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 3,
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:7]              segs,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  input  logic                    err_clr,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    update,
  output logic [IDX_W-1:0]        update_idx,
  output logic [NUM_DIGITS-1:0]   err
);

  localparam logic [7:0] STABLE   = 8'(STABLE_CYCLES);
  localparam bit         ONE_SHOT = (STABLE_CYCLES == 1);

  state_t                state, state_n;
  logic [1:7]            ref_segs;
  logic [NUM_DIGITS-1:0] ref_sel;
  logic [7:0]            run, run_n;
  logic                  legal, fresh, load, commit;
  logic                  is_numeral, is_blank;
  logic [3:0]            dec_bcd;
  logic [IDX_W-1:0]      sel_idx;

  seg7_pattern_lookup u_lookup (
    .segs       (segs),
    .is_numeral (is_numeral),
    .is_blank   (is_blank),
    .bcd        (dec_bcd)
  );

  assign legal = $onehot(dig_sel);
  assign fresh = (state == IDLE) || ({segs, dig_sel} != {ref_segs, ref_sel});

  always_comb begin
    sel_idx = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++)
      if (dig_sel[i]) sel_idx = IDX_W'(i);
  end

  always_comb begin
    state_n = state;
    run_n   = run;
    load    = 1'b0;
    commit  = 1'b0;
    if (!legal) begin
      state_n = IDLE;
      run_n   = '0;
    end else if (fresh) begin
      load  = 1'b1;
      run_n = 8'd1;
      if (ONE_SHOT) begin
        commit  = 1'b1;
        state_n = HOLD;
      end else begin
        state_n = QUALIFY;
      end
    end else if (state == QUALIFY) begin
      run_n = run + 8'd1;
      if (run_n == STABLE) begin
        commit  = 1'b1;
        state_n = HOLD;
      end
    end
    // HOLD with a matching sample keeps run saturated at STABLE
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      run      <= '0;
      ref_segs <= '0;
      ref_sel  <= '0;
    end else begin
      state <= state_n;
      run   <= run_n;
      if (load) begin
        ref_segs <= segs;
        ref_sel  <= dig_sel;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd_out     <= '0;
      digit_valid <= '0;
      update      <= 1'b0;
      update_idx  <= '0;
      err         <= '0;
    end else begin
      update <= commit;
      if (commit) update_idx <= sel_idx;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (commit && dig_sel[i] && !is_numeral && !is_blank)
          err[i] <= 1'b1;
        else if (err_clr)
          err[i] <= 1'b0;
        if (commit && dig_sel[i]) begin
          if (is_numeral) begin
            bcd_out[4*i +: 4] <= dec_bcd;
            digit_valid[i]    <= 1'b1;
          end else if (is_blank) begin
            digit_valid[i] <= 1'b0;
          end
        end
      end
    end
  end

endmodule
